register_file: RTL and testbench

//  Parametrised multi-entry register storage: DEPTH words of WIDTH bits each.
//  - One synchronous write port and two asynchronous read ports.
//  - Generalises the single enabled register to an addressable array.
//  - Sits in the datapath as the CPU's architectural register file; the ALU

---
 rtl/register_file.sv | 59 +++++
 tb/tb_register_file.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// DEPTH x WIDTH register file: one synchronous write port, two combinational read ports.
// Optional write-through forwarding to both read ports when REGFILE_BYPASS_EN is defined.
module register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_ena,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] wr_addr,
    input  logic [WIDTH-1:0]                      wr_data,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_addr0,
    output logic [WIDTH-1:0]                      rd_data0,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_addr1,
    output logic [WIDTH-1:0]                      rd_data1
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    function automatic logic addr_writable(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_L) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    assign wr_ok = wr_ena && !rst && addr_writable(wr_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Unwritable addresses (out of range, or the hard-wired zero entry) always read 0.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if (!rst && addr_writable(addr)) begin
            val = mem[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (addr == wr_addr)) begin
                val = wr_data;
            end
`endif
        end
        return val;
    endfunction

    assign rd_data0 = read_port(rd_addr0);
    assign rd_data1 = read_port(rd_addr1);

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: default instance, ZERO_REG=0 instance and DEPTH=24
// instance share all inputs so each directed vector exercises all three.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic [31:0] nz_data0, nz_data1;
    logic [31:0] d24_data0, d24_data1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rv [8];
    logic [31:0] exp_v;

    register_file u_dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(rd_data0), .rd_addr1(rd_addr1), .rd_data1(rd_data1)
    );

    register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(nz_data0), .rd_addr1(rd_addr1), .rd_data1(nz_data1)
    );

    register_file #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1)) u_dut24 (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(d24_data0), .rd_addr1(rd_addr1), .rd_data1(d24_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_ena  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0;
        tick(); tick();
        rst = 1'b0;
        rd_addr0 = 5'd3; rd_addr1 = 5'd17;
        #1;
        check("reset_rd0", rd_data0, 32'h0);
        check("reset_rd1", rd_data1, 32'h0);

        // random writes, then asynchronous reset mid-cycle
        for (int i = 0; i < 8; i++) begin
            rv[i] = $urandom | 32'h1;
            wr(5'(i), rv[i]);
        end
        rd_addr0 = 5'd3; rd_addr1 = 5'd0;
        #1;
        check("rand_rd3", rd_data0, rv[3]);
        check("rand_zero", rd_data1, 32'h0);
        check("rand_nz0", nz_data1, rv[0]);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rd3", rd_data0, 32'h0);
        check("async_rst_nz0", nz_data1, 32'h0);

        // write attempt while reset is held
        wr_ena = 1'b1; wr_addr = 5'd4; wr_data = 32'h5555_5555;
        tick(); tick();
        wr_ena = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i);
            #1;
            check($sformatf("rst_all_p0[%0d]", i), rd_data0, 32'h0);
            check($sformatf("rst_all_p1[%0d]", 31 - i), rd_data1, 32'h0);
        end

        // release reset just before an edge that carries a write
        @(posedge clk);
        #7;
        wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
        rst = 1'b0;
        tick();
        wr_ena = 1'b0;
        rd_addr0 = 5'd4; rd_addr1 = 5'd9;
        #1;
        check("rst_wins_rd4", rd_data0, 32'h0);
        check("rel_write_rd9", rd_data1, 32'h0000_0099);

        // fill 1..31, each visible one cycle after its write
        for (int i = 1; i < 32; i++) begin
            rd_addr0 = 5'(i);
            wr(5'(i), 32'hA500_0000 + 32'(i));
            check($sformatf("fill_rd[%0d]", i), rd_data0, 32'hA500_0000 + 32'(i));
        end
        for (int i = 1; i < 32; i++) begin
            rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i);
            #1;
            check($sformatf("dual_p0[%0d]", i), rd_data0, 32'hA500_0000 + 32'(i));
            exp_v = (i == 31) ? 32'h0 : 32'hA500_0000 + 32'(31 - i);
            check($sformatf("dual_p1[%0d]", 31 - i), rd_data1, exp_v);
        end
        rd_addr0 = 5'd12; rd_addr1 = 5'd12;
        #1;
        check("same_addr_p0", rd_data0, 32'hA500_000C);
        check("same_addr_p1", rd_data1, 32'hA500_000C);

        // hold: wr_ena low for 10 cycles
        wr_ena = 1'b0; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rd_addr0 = 5'd5;
        for (int i = 0; i < 10; i++) tick();
        check("hold_rd5", rd_data0, 32'hA500_0005);

        // zero register
        rd_addr0 = 5'd0;
        wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        #1;
        check("zero_pre_edge", rd_data0, 32'h0);
        tick();
        wr_ena = 1'b0;
        check("zero_reg1", rd_data0, 32'h0);
        check("zero_reg0", nz_data0, 32'hFFFF_FFFF);

        // same-cycle write/read of address 7
        rd_addr0 = 5'd7; rd_addr1 = 5'd8;
        wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_pre_edge", rd_data0, 32'h0000_1234);
`else
        check("nobypass_pre_edge", rd_data0, 32'hA500_0007);
`endif
        check("other_port_pre_edge", rd_data1, 32'hA500_0008);
        tick();
        wr_ena = 1'b0;
        check("wr7_post_edge", rd_data0, 32'h0000_1234);

        // DEPTH=24: out-of-range write and read
        rd_addr0 = 5'd28;
        wr_ena = 1'b1; wr_addr = 5'd28; wr_data = 32'h0000_CAFE;
        #1;
        check("d24_oor_pre_edge", d24_data0, 32'h0);
        tick();
        wr_ena = 1'b0;
        check("d24_oor_rd28", d24_data0, 32'h0);
        check("d32_rd28", rd_data0, 32'h0000_CAFE);
        for (int i = 0; i < 24; i++) begin
            rd_addr1 = 5'(i);
            #1;
            if (i == 0)      exp_v = 32'h0;
            else if (i == 7) exp_v = 32'h0000_1234;
            else             exp_v = 32'hA500_0000 + 32'(i);
            check($sformatf("d24_keep[%0d]", i), d24_data1, exp_v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
